// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN weight double-buffer.
// Contents: weight-buffer FSM state type, word-count and index-width helpers.
package cnn_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_LOAD = 2'd1,
    WB_PEND = 2'd2
  } wbuf_state_t;

  // Words per bank: n features of k*k taps each.
  function automatic int unsigned total_words(input int unsigned k, input int unsigned n);
    return n * k * k;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/weight_load_ctrl.sv
// Load/swap controller for the weight double-buffer: FSM, word counter,
// stream handshake, done pulses and the active-bank select register.
// Optional feature macro: WEIGHT_CKSUM_EN (adds in_data / load_cksum).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load_start        begin loading the shadow bank (honoured in IDLE only)
//   in_valid          stream word valid
//   pe_busy           blocks the bank swap while high
//   in_ready          stream ready, high only in LOAD
//   load_done         1-cycle pulse after the last word is accepted
//   swap_done         1-cycle pulse after the active bank flips
//   active_bank       bank currently driving the PEs
//   busy              state != IDLE
//   wr_en_c           combinational write strobe for the shadow bank
//   wr_feat_c/wr_tap_c combinational write address (feature-major, tap-minor)
//   in_data/load_cksum checksum input and running sum (WEIGHT_CKSUM_EN only)
module weight_load_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE  = 4,
  parameter int unsigned NUM_FEATURES = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  localparam int unsigned TAPS  = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned TOTAL = total_words(KERNEL_SIZE, NUM_FEATURES),
  localparam int unsigned CW    = clog2_min1(TOTAL),
  localparam int unsigned FW    = clog2_min1(NUM_FEATURES),
  localparam int unsigned TW    = clog2_min1(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic          pe_busy,
  output logic          in_ready,
  output logic          load_done,
  output logic          swap_done,
  output logic          active_bank,
  output logic          busy,
  output logic          wr_en_c,
  output logic [FW-1:0] wr_feat_c,
  output logic [TW-1:0] wr_tap_c
`ifdef WEIGHT_CKSUM_EN
  ,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [15:0]           load_cksum
`endif
);

  wbuf_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          load_done_q, load_done_d;
  logic          swap_done_q, swap_done_d;
  logic          bank_sel_q, bank_sel_d;
  logic          busy_q, busy_d;
  logic          last_word;
`ifdef WEIGHT_CKSUM_EN
  logic [15:0]   cksum_q, cksum_d;
`endif

  // Shadow-bank write strobe and address decode from the word counter.
  assign wr_en_c   = in_valid && in_ready_q;
  assign wr_feat_c = FW'(32'(cnt_q) / TAPS);
  assign wr_tap_c  = TW'(32'(cnt_q) % TAPS);
  assign last_word = (cnt_q == CW'(TOTAL - 1));

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_sel_d  = bank_sel_q;
    load_done_d = 1'b0;
    swap_done_d = 1'b0;
`ifdef WEIGHT_CKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      WB_IDLE: begin
        if (load_start) begin
          state_d = WB_LOAD;
          cnt_d   = '0;
`ifdef WEIGHT_CKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      WB_LOAD: begin
        if (wr_en_c) begin
`ifdef WEIGHT_CKSUM_EN
          cksum_d = cksum_q + 16'($signed(in_data));
`endif
          // The counter holds on the last word so it can never wrap.
          if (last_word) begin
            state_d     = WB_PEND;
            load_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WB_PEND: begin
        if (!pe_busy) begin
          state_d     = WB_IDLE;
          bank_sel_d  = ~bank_sel_q;
          swap_done_d = 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
    in_ready_d = (state_d == WB_LOAD);
    busy_d     = (state_d != WB_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WB_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      swap_done_q <= 1'b0;
      bank_sel_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WEIGHT_CKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      load_done_q <= load_done_d;
      swap_done_q <= swap_done_d;
      bank_sel_q  <= bank_sel_d;
      busy_q      <= busy_d;
`ifdef WEIGHT_CKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign load_done   = load_done_q;
  assign swap_done   = swap_done_q;
  assign active_bank = bank_sel_q;
  assign busy        = busy_q;
`ifdef WEIGHT_CKSUM_EN
  assign load_cksum  = cksum_q;
`endif

endmodule

// File: rtl/feature_weight_dbuf.sv
// Double-buffered feature-weight store for the CNN PE array. A serial
// valid/ready stream fills the shadow bank while the PEs read the active
// bank; banks swap once the load is complete and the PEs are idle.
// Optional feature macro: WEIGHT_CKSUM_EN (adds the load_cksum port).
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load_start    begin a shadow-bank load
//   in_valid/in_ready/in_data  weight stream
//   pe_busy       PEs still using active weights, defers the swap
//   load_done     pulse: last word accepted
//   swap_done     pulse: active bank flipped
//   active_bank   bank driving weights_out
//   busy          controller not idle
//   weights_out   full active bank [feature][tap], read straight from storage
//   load_cksum    wrapping 16-bit sum of accepted words (WEIGHT_CKSUM_EN only)
module feature_weight_dbuf
  import cnn_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE  = 4,
  parameter int unsigned NUM_FEATURES = 3,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  pe_busy,
  output logic                  load_done,
  output logic                  swap_done,
  output logic                  active_bank,
  output logic                  busy,
  output logic [NUM_FEATURES-1:0][KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weights_out
`ifdef WEIGHT_CKSUM_EN
  ,
  output logic [15:0]           load_cksum
`endif
);

  localparam int unsigned TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned FW   = clog2_min1(NUM_FEATURES);
  localparam int unsigned TW   = clog2_min1(TAPS);

  typedef logic [NUM_FEATURES-1:0][TAPS-1:0][DATA_WIDTH-1:0] bank_t;

  bank_t         bank_q [2];
  bank_t         bank_d [2];
  logic          wr_en_c;
  logic [FW-1:0] wr_feat_c;
  logic [TW-1:0] wr_tap_c;

  weight_load_ctrl #(
    .KERNEL_SIZE  (KERNEL_SIZE),
    .NUM_FEATURES (NUM_FEATURES),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .pe_busy     (pe_busy),
    .in_ready    (in_ready),
    .load_done   (load_done),
    .swap_done   (swap_done),
    .active_bank (active_bank),
    .busy        (busy),
    .wr_en_c     (wr_en_c),
    .wr_feat_c   (wr_feat_c),
    .wr_tap_c    (wr_tap_c)
`ifdef WEIGHT_CKSUM_EN
    ,
    .in_data     (in_data),
    .load_cksum  (load_cksum)
`endif
  );

  // Accepted words only ever land in the shadow (inactive) bank.
  always_comb begin
    bank_d = bank_q;
    if (wr_en_c) begin
      bank_d[~active_bank][wr_feat_c][wr_tap_c] = in_data;
    end
  end

  // Weight storage, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  // Output mux: the active bank feeds the PE array directly.
  assign weights_out = bank_q[active_bank];

endmodule

// File: tb/tb_feature_weight_dbuf.sv
// Directed self-checking bench for feature_weight_dbuf (K=4, N=3, 48 words).
module tb_feature_weight_dbuf;

  localparam int unsigned K     = 4;
  localparam int unsigned NF    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned TAPS  = K * K;
  localparam int unsigned TOTAL = NF * TAPS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          pe_busy = 1'b0;
  logic          load_done;
  logic          swap_done;
  logic          active_bank;
  logic          busy;
  logic [NF-1:0][TAPS-1:0][DW-1:0] weights_out;
`ifdef WEIGHT_CKSUM_EN
  logic [15:0]   load_cksum;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_act [TOTAL];
  int exp_sh  [TOTAL];
  int exp_bank = 0;

  feature_weight_dbuf #(
    .KERNEL_SIZE  (K),
    .NUM_FEATURES (NF),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .pe_busy     (pe_busy),
    .load_done   (load_done),
    .swap_done   (swap_done),
    .active_bank (active_bank),
    .busy        (busy),
    .weights_out (weights_out)
`ifdef WEIGHT_CKSUM_EN
    ,
    .load_cksum  (load_cksum)
`endif
  );

  always #5 clk = ~clk;

  // Number of weights_out entries differing from the expected active bank.
  function automatic int wout_bad();
    int n;
    logic [DW-1:0] e;
    n = 0;
    for (int f = 0; f < NF; f++) begin
      for (int t = 0; t < TAPS; t++) begin
        e = DW'(exp_act[f*TAPS+t]);
        if (weights_out[f][t] !== e) n++;
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Stream words from_w..to_w with value first+step*w, optionally with a
  // one-cycle in_valid gap before each word.
  task automatic stream(input int first, input int step, input int from_w, input int to_w,
                        input bit gaps, input bit expect_done);
    int rdy_bad, stab_bad, done_bad, v;
    rdy_bad = 0; stab_bad = 0; done_bad = 0;
    for (int w = from_w; w <= to_w; w++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
        if (in_ready !== 1'b1) rdy_bad++;
      end
      if (in_ready !== 1'b1) rdy_bad++;
      if (wout_bad() != 0) stab_bad++;
      if (load_done !== 1'b0) done_bad++;
      v = first + step * w;
      exp_sh[w] = v;
      in_valid = 1'b1;
      in_data  = DW'(v);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (rdy_bad != 0) begin
      failures++;
      $display("FAIL stream_in_ready: low cycles=%0d required 0", rdy_bad);
    end
    checks++;
    if (stab_bad != 0) begin
      failures++;
      $display("FAIL stream_active_stable: changed cycles=%0d required 0", stab_bad);
    end
    checks++;
    if (done_bad != 0) begin
      failures++;
      $display("FAIL stream_early_done: load_done cycles=%0d required 0", done_bad);
    end
    checks++;
    if (load_done !== expect_done) begin
      failures++;
      $display("FAIL stream_load_done: got %0b required %0b", load_done, expect_done);
    end
    checks++;
    if (in_ready !== !expect_done) begin
      failures++;
      $display("FAIL stream_ready_after: got %0b required %0b", in_ready, !expect_done);
    end
  endtask

  // Drop pe_busy; the following edge must swap banks.
  task automatic finish_swap();
    pe_busy = 1'b0;
    tick();
    exp_bank = 1 - exp_bank;
    exp_act  = exp_sh;
    checks++;
    if (swap_done !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL swap_pulse: swap_done=%0b load_done=%0b required 1 0", swap_done, load_done);
    end
    checks++;
    if (active_bank !== exp_bank[0] || busy !== 1'b0) begin
      failures++;
      $display("FAIL swap_bank: active_bank=%0b busy=%0b required %0d 0", active_bank, busy, exp_bank);
    end
    checks++;
    if (wout_bad() != 0) begin
      failures++;
      $display("FAIL swap_contents: bad entries=%0d required 0", wout_bad());
    end
    tick();
    checks++;
    if (swap_done !== 1'b0) begin
      failures++;
      $display("FAIL swap_single_pulse: got %0b required 0", swap_done);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    checks++;
    if ({in_ready, load_done, swap_done, busy, active_bank} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %05b required 00000",
               {in_ready, load_done, swap_done, busy, active_bank});
    end
    checks++;
    if (weights_out !== '0) begin
      failures++;
      $display("FAIL reset_weights: got %0h required 0", weights_out);
    end
`ifdef WEIGHT_CKSUM_EN
    checks++;
    if (load_cksum !== 16'd0) begin
      failures++;
      $display("FAIL reset_cksum: got %0d required 0", load_cksum);
    end
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    start_load();
    stream(1, 1, 0, TOTAL - 1, 1'b0, 1'b1);
    finish_swap();
    checks++;
    if ($signed(weights_out[0][0]) !== 8'sd1 || $signed(weights_out[1][0]) !== 8'sd17 ||
        $signed(weights_out[2][15]) !== 8'sd48) begin
      failures++;
      $display("FAIL full_load_taps: [0][0]=%0d [1][0]=%0d [2][15]=%0d required 1 17 48",
               $signed(weights_out[0][0]), $signed(weights_out[1][0]), $signed(weights_out[2][15]));
    end
`ifdef WEIGHT_CKSUM_EN
    checks++;
    if (load_cksum !== 16'd1176) begin
      failures++;
      $display("FAIL full_load_cksum: got %0d required 1176", load_cksum);
    end
`endif
  endtask

  task automatic test_gaps();
    start_load();
    stream(1, 1, 0, TOTAL - 1, 1'b1, 1'b1);
    finish_swap();
  endtask

  task automatic test_pe_busy_hold();
    int bad;
    bad = 0;
    pe_busy = 1'b1;
    start_load();
    stream(61, 1, 0, TOTAL - 1, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy !== 1'b1 || swap_done !== 1'b0 || wout_bad() != 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pe_busy_hold: disturbed cycles=%0d required 0", bad);
    end
    finish_swap();
  endtask

  task automatic test_second_load();
    pe_busy = 1'b1;
    start_load();
    stream(-1, -1, 0, TOTAL - 1, 1'b0, 1'b1);
    tick();
    checks++;
    if ($signed(weights_out[0][0]) !== 8'sd61) begin
      failures++;
      $display("FAIL second_load_hold: [0][0]=%0d required 61", $signed(weights_out[0][0]));
    end
    finish_swap();
    checks++;
    if ($signed(weights_out[0][0]) !== -8'sd1 || active_bank !== 1'b0) begin
      failures++;
      $display("FAIL second_load_new: [0][0]=%0d bank=%0b required -1 0",
               $signed(weights_out[0][0]), active_bank);
    end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    stream(5, 1, 0, 9, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    for (int w = 0; w < TOTAL; w++) begin
      exp_act[w] = 0;
      exp_sh[w]  = 0;
    end
    exp_bank = 0;
    checks++;
    if ({in_ready, load_done, swap_done, busy, active_bank} !== 5'b0 || weights_out !== '0) begin
      failures++;
      $display("FAIL reset_mid_load: ctrl=%05b weights nonzero=%0b required 00000 0",
               {in_ready, load_done, swap_done, busy, active_bank}, weights_out !== '0);
    end
    tick();
    rst = 1'b1;
    tick();
    start_load();
    stream(1, 1, 0, TOTAL - 1, 1'b0, 1'b1);
    finish_swap();
`ifdef WEIGHT_CKSUM_EN
    checks++;
    if (load_cksum !== 16'd1176) begin
      failures++;
      $display("FAIL reload_cksum: got %0d required 1176", load_cksum);
    end
`endif
  endtask

  task automatic test_ignored_inputs();
    pe_busy = 1'b1;
    start_load();
    stream(-40, 2, 0, 19, 1'b0, 1'b0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    stream(-40, 2, 20, TOTAL - 1, 1'b0, 1'b1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL pend_load_start: busy=%0b in_ready=%0b required 1 0", busy, in_ready);
    end
    finish_swap();
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || wout_bad() != 0) begin
      failures++;
      $display("FAIL idle_in_valid: in_ready=%0b busy=%0b bad=%0d required 0 0 0",
               in_ready, busy, wout_bad());
    end
  endtask

  initial begin
    for (int w = 0; w < TOTAL; w++) begin
      exp_act[w] = 0;
      exp_sh[w]  = 0;
    end
    test_reset();
    test_full_load();
    test_gaps();
    test_pe_busy_hold();
    test_second_load();
    test_reset_mid_load();
    test_ignored_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
